sap_ram_ctrl: RTL and testbench
===============================

// Module: sap_ram_ctrl
// PURPOSE
//  Parametrised, clocked RAM with an integrated memory address register (MAR), a tri-state bus port and a
//  streaming program loader. Sits on the shared 8-bit bus; the controller drives active-low strobes.
//  Successor to the 16x8 asynchronous RAM: synchronous writes, owned MAR, loader FSM, optional reset clear.
// PARAMETERS
//  DATA_WIDTH  8  word width; also the bus width
//  ADDR_WIDTH  4  address bits; depth = 2**ADDR_WIDTH; MAR loads from bus_in[ADDR_WIDTH-1:0]
// PORTS
//  clk         in   1           single clock, all state updates on posedge
//  reset       in   1           synchronous, active-high
//  bus_in      in   DATA_WIDTH  bus value, sampled for MAR load and RAM write
//  mar_load_n  in   1           active-low: MAR <= bus_in[ADDR_WIDTH-1:0]
//  ram_write_n in   1           active-low: mem[MAR] <= bus_in
//  ram_out_n   in   1           active-low: drive mem[MAR] onto bus_out
//  bus_out     out  DATA_WIDTH  tri-state read data, 'z when not driving
//  mar_out     out  ADDR_WIDTH  current MAR value (display LEDs)
//  prog_mode   in   1           high requests/holds program-loader mode
//  prog_data   in   DATA_WIDTH  loader write data
//  prog_valid  in   1           loader data valid
//  prog_ready  out  1           loader accepts a word this cycle
//  prog_done   out  1           all 2**ADDR_WIDTH words loaded
//  busy        out  1           high while not in RUN
// BEHAVIOUR
//  States: RUN, PROG, DONE (+CLEAR with macro). Reset -> RUN. Resets: MAR=0, prog_addr=0, prog_ready=0,
//  prog_done=0, busy=0, bus_out='z. Without the macro, memory contents are untouched by reset (X after power-up).
//  RUN:
//   - mar_load_n=0: MAR updates at the edge.
//   - ram_write_n=0: mem[MAR] written at the edge using the pre-edge MAR. Both strobes low together: the write
//     uses the old MAR, and MAR takes the new value.
//   - Read is combinational: bus_out = (!ram_out_n) ? mem[MAR] : 'z. During a same-cycle write, bus_out shows old
//     data until the edge, new data after.
//   - prog_mode=1 at an edge: goes to PROG, prog_addr=0. Strobes sampled in that same cycle still take effect.
//  PROG:
//   - prog_ready=1, busy=1. mar_load_n, ram_write_n and ram_out_n are ignored; bus_out='z.
//   - prog_valid&prog_ready: mem[prog_addr] <= prog_data, prog_addr++. The write at prog_addr = 2**ADDR_WIDTH-1
//     goes to DONE; no wrap.
//   - prog_mode=0 (abort): goes to RUN next edge; words already written are kept; prog_done stays 0.
//  DONE:
//   - prog_ready=0, prog_done=1, busy=1. Held until prog_mode=0, then RUN, where prog_done=0 and busy=0.
//   - prog_valid is ignored here.
//  Control: MAR is unchanged by PROG/DONE. reset in any state forces the reset values at the next edge.
//  Widths: prog_addr is ADDR_WIDTH+1 bits internally so terminal detection needs no wrap; bus_in upper bits are
//  ignored for MAR.
// CONFIGURATION
//  RAM_CLEAR_ON_RESET_EN defined:
//   - Reset enters CLEAR instead of RUN. CLEAR writes 0 to mem[clr_addr] once per cycle, addresses
//     0..2**ADDR_WIDTH-1, with busy=1, bus_out='z and all strobes and prog_mode ignored.
//   - The cycle after the last address goes to RUN. Total 2**ADDR_WIDTH cycles after reset deasserts.
//   - reset asserted mid-clear restarts from address 0.
//  RAM_CLEAR_ON_RESET_EN undefined: no CLEAR state and no clearing logic. The busy port still exists and tracks
//  PROG/DONE only.
// TESTING
//  T1 Write/read at defaults:
//   - Stimulus: mar_load_n=0 with bus_in=0x02; then ram_write_n=0 with bus_in=0xAA; then MAR=0x5 and write 0xCC.
//   - Response: MAR=2, ram_out_n=0 -> bus_out=0xAA; MAR=5 -> bus_out=0xCC; ram_out_n=1 -> bus_out='z.
//  T2 Simultaneous strobes:
//   - Stimulus: MAR=3, then mar_load_n=0 and ram_write_n=0 in one cycle with bus_in=0x07.
//   - Response: mem[3]=0x07, MAR=7, mem[7] unchanged.
//  T3 Full program load:
//   - Stimulus: prog_mode=1; stream 16 words 0x10+i with prog_valid gaps on i=4,9.
//   - Response: prog_done=1 after the 16th accept, prog_ready=0 in DONE. After prog_mode=0, reading addr i
//     returns 0x10+i.
//  T4 Abort: prog_mode drops after 5 words -> RUN next edge, mem[0..4] written, mem[5..] unchanged, prog_done=0.
//  T5 Reset mid-PROG: reset during word 8 -> RUN, MAR=0, prog_ready=0, bus_out='z; words 0..7 retained.
//  T6 With macro (DATA_WIDTH=16, ADDR_WIDTH=3):
//   - Stimulus: preload nonzero words; pulse reset for 1 cycle.
//   - Response: busy=1 for 8 cycles, then all reads return 0x0000.
//   - Reset again at clear cycle 3: clear restarts, busy=1 for 8 more cycles.

Source files
------------

// File: rtl/sap_ram_ctrl.sv
// Clocked RAM with owned MAR, tri-state read port and streaming program loader.
// Optional RAM_CLEAR_ON_RESET_EN: reset zero-fills the memory before returning to RUN.
module sap_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mar_load_n,
    input  logic                  ram_write_n,
    input  logic                  ram_out_n,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [ADDR_WIDTH-1:0] mar_out,
    input  logic                  prog_mode,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_valid,
    output logic                  prog_ready,
    output logic                  prog_done,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PROG,
        S_DONE
`ifdef RAM_CLEAR_ON_RESET_EN
        , S_CLEAR
`endif
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] mar;
    logic [ADDR_WIDTH:0]   prog_addr;
`ifdef RAM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_addr;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    // Single write port shared by bus writes, loader writes and clearing; reset suppresses all writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = mar;
        mem_wd = bus_in;
        if (!reset) begin
            case (state)
                S_RUN: mem_we = !ram_write_n;
                S_PROG: begin
                    if (prog_valid && prog_ready) begin
                        mem_we = 1'b1;
                        mem_wa = prog_addr[ADDR_WIDTH-1:0];
                        mem_wd = prog_data;
                    end
                end
`ifdef RAM_CLEAR_ON_RESET_EN
                S_CLEAR: begin
                    mem_we = 1'b1;
                    mem_wa = clr_addr;
                    mem_wd = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mar        <= '0;
            prog_addr  <= '0;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
            state      <= S_CLEAR;
            clr_addr   <= '0;
            busy       <= 1'b1;
`else
            state      <= S_RUN;
            busy       <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    if (!mar_load_n) mar <= bus_in[ADDR_WIDTH-1:0];
                    if (prog_mode) begin
                        state      <= S_PROG;
                        prog_addr  <= '0;
                        prog_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_PROG: begin
                    // A handshake in the abort cycle is still written; abort wins over DONE.
                    if (prog_valid) prog_addr <= prog_addr + 1'b1;
                    if (!prog_mode) begin
                        state      <= S_RUN;
                        prog_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (prog_valid && prog_addr == LAST_ADDR) begin
                        state      <= S_DONE;
                        prog_ready <= 1'b0;
                        prog_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!prog_mode) begin
                        state     <= S_RUN;
                        prog_done <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
`ifdef RAM_CLEAR_ON_RESET_EN
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: state <= S_RUN;
            endcase
        end
    end

    assign mar_out = mar;
    assign bus_out = (state == S_RUN && !ram_out_n) ? mem[mar] : 'z;

endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Self-checking bench for sap_ram_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_sap_ram_ctrl;
`ifdef RAM_CLEAR_ON_RESET_EN
    localparam int DW = 16;
    localparam int AW = 3;
`else
    localparam int DW = 8;
    localparam int AW = 4;
`endif
    localparam int DEPTH = 2 ** AW;
    localparam logic [31:0] ONES = {{(32 - DW){1'b0}}, {DW{1'b1}}};
    localparam int PH_RUN = 0, PH_PROG = 1, PH_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, mar_load_n, ram_write_n, ram_out_n, prog_mode, prog_valid;
    logic [DW-1:0] bus_in, prog_data;
    tri1  [DW-1:0] bus_out;
    logic [AW-1:0] mar_out;
    logic          prog_ready, prog_done, busy;

    sap_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .mar_load_n(mar_load_n),
        .ram_write_n(ram_write_n), .ram_out_n(ram_out_n), .bus_out(bus_out),
        .mar_out(mar_out), .prog_mode(prog_mode), .prog_data(prog_data),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_done(prog_done), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_mar = 0, m_phase = PH_RUN, m_paddr = 0, m_clear = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the spec rules, advanced once per rising edge with the inputs held during that cycle.
    task automatic model_step();
        if (reset) begin
            m_mar = 0; m_phase = PH_RUN; m_paddr = 0;
`ifdef RAM_CLEAR_ON_RESET_EN
            m_clear = DEPTH;
`endif
        end else if (m_clear > 0) begin
            m_mem[DEPTH - m_clear] = '0;
            m_known[DEPTH - m_clear] = 1'b1;
            m_clear--;
        end else begin
            case (m_phase)
                PH_RUN: begin
                    if (!ram_write_n) begin m_mem[m_mar] = bus_in; m_known[m_mar] = 1'b1; end
                    if (!mar_load_n) m_mar = int'(bus_in) % DEPTH;
                    if (prog_mode) begin m_phase = PH_PROG; m_paddr = 0; end
                end
                PH_PROG: begin
                    if (prog_valid) begin
                        m_mem[m_paddr] = prog_data; m_known[m_paddr] = 1'b1;
                        m_paddr++;
                        if (m_paddr == DEPTH) m_phase = PH_DONE;
                    end
                    if (!prog_mode) m_phase = PH_RUN;
                end
                PH_DONE: if (!prog_mode) m_phase = PH_RUN;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mar_out", mar_out, m_mar);
            chk("prog_ready", prog_ready, (m_clear == 0 && m_phase == PH_PROG));
            chk("prog_done", prog_done, (m_clear == 0 && m_phase == PH_DONE));
            chk("busy", busy, (m_clear > 0 || m_phase != PH_RUN));
            if (m_clear == 0 && m_phase == PH_RUN && !ram_out_n) begin
                if (m_known[m_mar]) chk("bus_read", bus_out, m_mem[m_mar]);
            end else begin
                chk("bus_z", bus_out, ONES);
            end
        end
    end

    task automatic idle();
        reset = 1'b0; mar_load_n = 1'b1; ram_write_n = 1'b1; ram_out_n = 1'b1;
        prog_mode = 1'b0; prog_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_mar(input int a);
        idle(); mar_load_n = 1'b0; bus_in = DW'(a); tick(); idle();
    endtask

    task automatic write_word(input int d);
        idle(); ram_write_n = 1'b0; bus_in = DW'(d); tick(); idle();
    endtask

    task automatic read_lit(input string name, input int a, input int exp);
        load_mar(a); ram_out_n = 1'b0; #2; chk(name, bus_out, exp); idle();
    endtask

    task automatic wait_clear();
`ifdef RAM_CLEAR_ON_RESET_EN
        int n = 0;
        while (busy && n < DEPTH + 4) begin n++; tick(); end
        chk("clear_busy_len", n, DEPTH);
`endif
    endtask

    initial begin
        int i, k;
        bit gap4, gap9;
        bus_in = '0; prog_data = '0;
        idle();
        reset = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        idle();
        #2;
        chk("rst_mar", mar_out, 0);
        chk("rst_ready", prog_ready, 0);
        chk("rst_done", prog_done, 0);
        chk("rst_bus_z", bus_out, ONES);
        wait_clear();

        // T1: basic write/read and same-cycle write visibility
        load_mar(2); write_word('hAA);
        load_mar(5); write_word('hCC);
        read_lit("t1_a2", 2, 'hAA);
        read_lit("t1_a5", 5, 'hCC);
        #2; chk("t1_z", bus_out, ONES);
        load_mar(2); ram_out_n = 1'b0; ram_write_n = 1'b0; bus_in = DW'('h55);
        #2; chk("t1_old_data", bus_out, 'hAA);
        tick(); ram_write_n = 1'b1;
        #2; chk("t1_new_data", bus_out, 'h55);
        idle();

        // T2: both strobes in one cycle
        load_mar(7); write_word('h77);
        load_mar(3);
        mar_load_n = 1'b0; ram_write_n = 1'b0; bus_in = DW'('h07);
        tick(); idle();
        chk("t2_mar", mar_out, 7);
        read_lit("t2_m7", 7, 'h77);
        read_lit("t2_m3", 3, 'h07);

        // T3: full load with valid gaps
        prog_mode = 1'b1; tick();
        i = 0; gap4 = 1'b0; gap9 = 1'b0;
        for (int c = 0; c < DEPTH + 10 && i < DEPTH; c++) begin
            prog_valid = 1'b1;
            if (i == 4 && !gap4) begin prog_valid = 1'b0; gap4 = 1'b1; end
            if (i == 9 && !gap9) begin prog_valid = 1'b0; gap9 = 1'b1; end
            prog_data = DW'('h10 + i);
            tick();
            if (prog_valid) i++;
        end
        prog_valid = 1'b0;
        chk("t3_accepts", i, DEPTH);
        chk("t3_done", prog_done, 1);
        chk("t3_ready", prog_ready, 0);
        prog_valid = 1'b1; prog_data = DW'('hEE); tick(); tick();
        prog_valid = 1'b0; prog_mode = 1'b0; tick();
        chk("t3_busy_off", busy, 0);
        for (int a = 0; a < DEPTH; a++) read_lit("t3_word", a, 'h10 + a);

        // T4: abort after 5 words
        prog_mode = 1'b1; tick();
        for (int w = 0; w < 5; w++) begin prog_valid = 1'b1; prog_data = DW'('h30 + w); tick(); end
        prog_valid = 1'b0; prog_mode = 1'b0; tick();
        chk("t4_busy", busy, 0);
        chk("t4_done", prog_done, 0);
        for (int a = 0; a < 5; a++) read_lit("t4_word", a, 'h30 + a);
        read_lit("t4_kept", 5, 'h15);

        // T5: reset while presenting word K
        k = DEPTH / 2;
        prog_mode = 1'b1; tick();
        for (int w = 0; w < k; w++) begin prog_valid = 1'b1; prog_data = DW'('h50 + w); tick(); end
        prog_data = DW'('h50 + k); reset = 1'b1; tick();
        idle(); prog_mode = 1'b1;
        #2;
        chk("t5_mar", mar_out, 0);
        chk("t5_ready", prog_ready, 0);
        chk("t5_bus_z", bus_out, ONES);
        prog_mode = 1'b0;
        wait_clear();
`ifndef RAM_CLEAR_ON_RESET_EN
        for (int a = 0; a < k; a++) read_lit("t5_word", a, 'h50 + a);
        read_lit("t5_untouched", k, 'h10 + k);
`endif

`ifdef RAM_CLEAR_ON_RESET_EN
        // T6: clear restart mid-way, then memory reads zero
        for (int a = 0; a < DEPTH; a++) begin load_mar(a); write_word('hA000 + a); end
        reset = 1'b1; tick(); idle();
        tick(); tick(); tick();
        reset = 1'b1; tick(); idle();
        wait_clear();
        for (int a = 0; a < DEPTH; a++) read_lit("t6_zero", a, 0);
`endif

        // Randomized traffic against the model
        idle();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) prog_mode = ~prog_mode;
            mar_load_n  = 1'($urandom_range(0, 1));
            ram_write_n = 1'($urandom_range(0, 1));
            ram_out_n   = 1'($urandom_range(0, 1));
            prog_valid  = ($urandom_range(0, 9) < 7);
            bus_in      = DW'($urandom);
            prog_data   = DW'($urandom);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
